quadrature_decoder: RTL and testbench
=====================================

# quadrature_decoder

Decodes a two-channel quadrature encoder (A/B) into a single-cycle `step` pulse and a registered direction bit. It sits directly upstream of the 8-bit up/down counter: `up_down` drives the counter's direction input and `step` is the counter's count enable. It also synchronizes and glitch-filters the asynchronous encoder pins, flags illegal transitions, and keeps a saturating error tally.

## Interface
- `FILTER_LEN`, default 4: consecutive cycles a synchronized input must hold a new level before it is accepted. Legal range 1..15.
- `ERR_W`, default 8: width of `err_count`.
- `clk` input 1: single clock; all logic rising-edge.
- `rst` input 1: reset, synchronous, active-low.
- `enc_a` input 1: encoder channel A, asynchronous.
- `enc_b` input 1: encoder channel B, asynchronous.
- `err_clr` input 1: synchronous clear of `err_count`.
- `step` output 1: one-cycle pulse per valid quadrature transition (x4 decoding).
- `up_down` output 1: 1 = up (A leads B), 0 = down. Updated with `step`; holds otherwise.
- `err` output 1: one-cycle pulse on an illegal transition.
- `err_count` output ERR_W: saturating count of illegal transitions.

## Operation
- **Synchronizer:** two flops per channel, `enc_x` → `s1_x` → `s2_x`. Reset value is 0.
- **Filter (per channel):**
  - Holds a filtered level `f_x` (reset 0) and a counter `cnt_x` (reset 0, 4 bits).
  - If `s2_x == f_x`, then `cnt_x` ← 0.
  - Otherwise, if `cnt_x == FILTER_LEN-1`, then `f_x` ← `s2_x` and `cnt_x` ← 0.
  - Otherwise `cnt_x` ← `cnt_x`+1.
  - Pulses shorter than FILTER_LEN cycles are rejected.
- **Decoder:** holds `prev` = registered {f_a, f_b}, reset 2'b00. Each cycle it compares `cur` = {f_a, f_b} with `prev`, then sets `prev` ← `cur`.
  - Up sequence, {A,B}: 00→10→11→01→00. These give `step`=1 and `up_down`=1.
  - Down sequence: 00→01→11→10→00. These give `step`=1 and `up_down`=0.
  - `cur == prev`: `step`=0, `up_down` holds.
  - Both bits changed in one cycle is illegal: `err`=1, `step`=0, `up_down` holds. `prev` still takes `cur`, so decoding resynchronizes.
- **Error counter:**
  - Increments on `err`.
  - Saturates at 2^ERR_W−1 (255 at the default width).
  - When `err_clr`=1, `err_count` ← 0. Clear wins over a simultaneous `err` increment.
- **Reset values** (`rst`=0 at a rising edge): all flops cleared.
  - `step`=0, `err`=0, `err_count`=0, `up_down`=1.
  - This applies regardless of encoder inputs and mid-sequence. Filter progress is discarded.
- **After reset:** `f` and `prev` are 00. If the pins rest at 11, both filters accept on the same cycle, which produces exactly one `err` pulse and no `step`. This is the required behaviour.

## Timing
- Edge 0 is the first rising edge that samples a new level on one channel. After that:
  - `s2` holds the new level after edge 1.
  - `f` updates at edge 1+FILTER_LEN.
  - `step` and `up_down` are registered at edge 2+FILTER_LEN.
  - `step` is high for exactly one cycle.
- Total latency is FILTER_LEN+3 edges (7 edges at the default FILTER_LEN=4).
- `err` has the same latency as `step`. `err_count` reflects the error one edge after `err` rises.
- `step` and `err` are never high in the same cycle.
- **Maximum decoded rate:** one accepted change per channel per FILTER_LEN cycles. Input faster than that is filtered away, not miscounted.
- All outputs are driven directly from flops; there are no combinational paths from inputs to outputs.

## Test plan
- **Reset:** hold `rst`=0 for 3 cycles while toggling `enc_a`/`enc_b` → `step`=0, `err`=0, `up_down`=1, `err_count`=0 throughout. No `step` in the 10 cycles after release with pins at 00.
- **Forward:** FILTER_LEN=4; drive 00→10→11→01→00, holding each code 10 cycles → exactly 4 `step` pulses with `up_down`=1. The first pulse is registered exactly 7 edges after the first edge sampling A=1.
- **Reverse:** drive 00→01→11→10→00 → 4 pulses with `up_down`=0 from the first pulse. A following single forward transition returns `up_down` to 1 with one pulse.
- **Glitch:** FILTER_LEN=4; drive `enc_a` high for 3 cycles, then low → no `step`. Then drive it high for 4 cycles → exactly one `step` with `up_down`=1.
- **Illegal/saturation:**
  - Drive 00→11 on the same edge → one `err` pulse, no `step`, `err_count`=1.
  - Repeat the toggle 300 times → `err_count`=255 and holds.
  - Assert `err_clr` in the same cycle as an `err` → `err_count`=0.
- **Reset mid-operation:** assert `rst`=0 while the pins are at 11 → outputs return to reset values. After release, exactly one `err` pulse arrives FILTER_LEN+3 edges later, with `err_count`=1 and no `step`.

Source files
------------

// File: rtl/quadrature_decoder.sv
// Quadrature A/B decoder: synchronizes and glitch-filters the encoder pins, then emits
// x4 step pulses with a direction bit, illegal-transition pulses and a saturating error tally.
module quadrature_decoder #(
    parameter int FILTER_LEN = 4,
    parameter int ERR_W      = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             enc_a_i,
    input  logic             enc_b_i,
    input  logic             err_clr_i,
    output logic             step_o,
    output logic             up_down_o,
    output logic             err_o,
    output logic [ERR_W-1:0] err_count_o
);

    localparam logic [3:0] CntMax = 4'(FILTER_LEN - 1);

    // Channel vectors are packed {A, B} so they line up with the quadrature codes.
    logic [1:0]       s1_q, s2_q;
    logic [1:0]       f_q, f_d;
    logic [3:0]       cnt_q [2];
    logic [3:0]       cnt_d [2];
    logic [1:0]       prev_q;
    logic             step_q, step_d;
    logic             up_q, up_d;
    logic             err_q, err_d;
    logic [ERR_W-1:0] err_count_q, err_count_d;

    always_comb begin
        f_d = f_q;
        for (int i = 0; i < 2; i++) begin
            cnt_d[i] = cnt_q[i];
            if (s2_q[i] == f_q[i]) begin
                cnt_d[i] = 4'd0;
            end else if (cnt_q[i] == CntMax) begin
                f_d[i]   = s2_q[i];
                cnt_d[i] = 4'd0;
            end else begin
                cnt_d[i] = cnt_q[i] + 4'd1;
            end
        end
    end

    always_comb begin
        step_d = 1'b0;
        err_d  = 1'b0;
        up_d   = up_q;
        case ({prev_q, f_q})
            4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: begin
                step_d = 1'b1;
                up_d   = 1'b1;
            end
            4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: begin
                step_d = 1'b1;
                up_d   = 1'b0;
            end
            4'b00_11, 4'b11_00, 4'b10_01, 4'b01_10: begin
                err_d = 1'b1;
            end
            default: ;
        endcase
    end

    // A clear request takes priority over an increment landing in the same cycle.
    always_comb begin
        err_count_d = err_count_q;
        if (err_clr_i) begin
            err_count_d = '0;
        end else if (err_q && (err_count_q != {ERR_W{1'b1}})) begin
            err_count_d = err_count_q + ERR_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            s1_q        <= 2'b00;
            s2_q        <= 2'b00;
            f_q         <= 2'b00;
            cnt_q[0]    <= 4'd0;
            cnt_q[1]    <= 4'd0;
            prev_q      <= 2'b00;
            step_q      <= 1'b0;
            up_q        <= 1'b1;
            err_q       <= 1'b0;
            err_count_q <= '0;
        end else begin
            s1_q        <= {enc_a_i, enc_b_i};
            s2_q        <= s1_q;
            f_q         <= f_d;
            cnt_q[0]    <= cnt_d[0];
            cnt_q[1]    <= cnt_d[1];
            prev_q      <= f_q;
            step_q      <= step_d;
            up_q        <= up_d;
            err_q       <= err_d;
            err_count_q <= err_count_d;
        end
    end

    assign step_o      = step_q;
    assign up_down_o   = up_q;
    assign err_o       = err_q;
    assign err_count_o = err_count_q;

endmodule

// File: tb/tb_quadrature_decoder.sv
// Bench for quadrature_decoder: directed scenarios followed by random encoder activity,
// every cycle compared against a sample-window / gray-position reference model.
module tb_quadrature_decoder;

    localparam int FL      = 4;
    localparam int EW      = 8;
    localparam int CNT_MAX = (1 << EW) - 1;

    logic          clk = 1'b0;
    logic          rstN = 1'b0;
    logic          encA = 1'b0;
    logic          encB = 1'b0;
    logic          errClr = 1'b0;
    logic          stepO, upDownO, errO;
    logic [EW-1:0] errCountO;

    int passCount = 0;
    int failCount = 0;
    int checkCount = 0;
    int stepSeen, errSeen, firstStepAt, firstErrAt;

    bit       qa[$], qb[$], wa[$], wb[$];
    bit       fa, fb;
    bit [1:0] prevM;
    bit       mStep, mErr;
    bit       mUp = 1'b1;
    int       mCnt;

    quadrature_decoder #(.FILTER_LEN(FL), .ERR_W(EW)) dut (
        .clk_i      (clk),
        .rst_i      (rstN),
        .enc_a_i    (encA),
        .enc_b_i    (encB),
        .err_clr_i  (errClr),
        .step_o     (stepO),
        .up_down_o  (upDownO),
        .err_o      (errO),
        .err_count_o(errCountO)
    );

    always #5 clk = ~clk;

    function automatic int gpos(bit [1:0] g);
        case (g)
            2'b00:   return 0;
            2'b10:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    // A level is accepted once the last FL synchronized samples all disagree with the filtered level;
    // decoding is done on positions around the gray cycle.
    task automatic modelEdge(bit a, bit b, bit clr, bit rn);
        bit       s2a, s2b;
        bit [1:0] cur;
        int       d, na, nb;
        if (!rn) begin
            qa = '{1'b0, 1'b0};
            qb = '{1'b0, 1'b0};
            wa.delete();
            wb.delete();
            fa = 0; fb = 0; prevM = 2'b00;
            mStep = 0; mErr = 0; mUp = 1; mCnt = 0;
            return;
        end
        if (clr) mCnt = 0;
        else if (mErr && mCnt < CNT_MAX) mCnt++;
        cur = {fa, fb};
        d = (gpos(cur) - gpos(prevM) + 4) % 4;
        mStep = (d == 1) || (d == 3);
        mErr  = (d == 2);
        if (d == 1) mUp = 1;
        else if (d == 3) mUp = 0;
        prevM = cur;
        s2a = qa.pop_front();
        qa.push_back(a);
        s2b = qb.pop_front();
        qb.push_back(b);
        wa.push_back(s2a);
        if (wa.size() > FL) void'(wa.pop_front());
        wb.push_back(s2b);
        if (wb.size() > FL) void'(wb.pop_front());
        na = 0;
        foreach (wa[i]) if (wa[i] != fa) na++;
        nb = 0;
        foreach (wb[i]) if (wb[i] != fb) nb++;
        if (na == FL) begin fa = !fa; wa.delete(); end
        if (nb == FL) begin fb = !fb; wb.delete(); end
    endtask

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checkCount++;
        assert (obs === exp) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic checkOutput();
        check("step", 32'(stepO), 32'(mStep));
        check("err", 32'(errO), 32'(mErr));
        check("up_down", 32'(upDownO), 32'(mUp));
        check("err_count", 32'(errCountO), 32'(mCnt));
    endtask

    task automatic clearTally();
        stepSeen = 0; errSeen = 0; firstStepAt = 0; firstErrAt = 0;
    endtask

    task automatic applyStimulus(bit a, bit b, bit clr, bit rn, int n);
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            encA = a; encB = b; errClr = clr; rstN = rn;
            @(posedge clk);
            modelEdge(a, b, clr, rn);
            #1;
            checkOutput();
            if (stepO === 1'b1) begin
                stepSeen++;
                if (firstStepAt == 0) firstStepAt = i;
            end
            if (errO === 1'b1) begin
                errSeen++;
                if (firstErrAt == 0) firstErrAt = i;
            end
        end
    endtask

    initial begin
        logic [1:0] codes [4];
        logic [1:0] c, g;
        int         pos, r, ch;
        codes[0] = 2'b00; codes[1] = 2'b10; codes[2] = 2'b11; codes[3] = 2'b01;

        // Reset held while the pins toggle, then a quiet release at 00.
        applyStimulus(1, 0, 0, 0, 1);
        applyStimulus(0, 1, 0, 0, 1);
        applyStimulus(1, 1, 0, 0, 1);
        clearTally();
        applyStimulus(0, 0, 0, 1, 10);
        check("rstNoStep", stepSeen, 0);

        // Forward rotation.
        clearTally();
        applyStimulus(1, 0, 0, 1, 10);
        check("fwdLatency", firstStepAt, FL + 3);
        applyStimulus(1, 1, 0, 1, 10);
        applyStimulus(0, 1, 0, 1, 10);
        applyStimulus(0, 0, 0, 1, 10);
        check("fwdSteps", stepSeen, 4);
        check("fwdDir", 32'(upDownO), 1);

        // Reverse rotation, then a single forward step.
        clearTally();
        applyStimulus(0, 1, 0, 1, 10);
        applyStimulus(1, 1, 0, 1, 10);
        applyStimulus(1, 0, 0, 1, 10);
        applyStimulus(0, 0, 0, 1, 10);
        check("revSteps", stepSeen, 4);
        check("revDir", 32'(upDownO), 0);
        clearTally();
        applyStimulus(1, 0, 0, 1, 10);
        check("backFwdSteps", stepSeen, 1);
        check("backFwdDir", 32'(upDownO), 1);
        applyStimulus(0, 0, 0, 1, 10);

        // Glitch rejection, then the shortest accepted pulse.
        clearTally();
        applyStimulus(1, 0, 0, 1, FL - 1);
        applyStimulus(0, 0, 0, 1, 10);
        check("glitchSteps", stepSeen, 0);
        clearTally();
        applyStimulus(1, 0, 0, 1, FL);
        applyStimulus(0, 0, 0, 1, 6);
        check("minPulseSteps", stepSeen, 1);
        check("minPulseDir", 32'(upDownO), 1);
        applyStimulus(0, 0, 0, 1, 10);

        // Illegal double change, saturation, clear against a simultaneous error.
        clearTally();
        applyStimulus(1, 1, 0, 1, 10);
        check("illegalErr", errSeen, 1);
        check("illegalStep", stepSeen, 0);
        check("illegalCount", 32'(errCountO), 1);
        for (int k = 0; k < 300; k++) begin
            applyStimulus(k[0], k[0], 0, 1, 8);
        end
        check("errSat", 32'(errCountO), CNT_MAX);
        clearTally();
        applyStimulus(0, 0, 0, 1, FL + 3);
        check("clrErrPulse", errSeen, 1);
        applyStimulus(0, 0, 1, 1, 1);
        check("clrWins", 32'(errCountO), 0);
        applyStimulus(0, 0, 0, 1, 5);
        check("clrHolds", 32'(errCountO), 0);

        // Reset mid-operation with the pins resting at 11.
        applyStimulus(1, 1, 0, 1, 10);
        applyStimulus(1, 1, 0, 0, 3);
        check("midRstCount", 32'(errCountO), 0);
        check("midRstDir", 32'(upDownO), 1);
        clearTally();
        applyStimulus(1, 1, 0, 1, 12);
        check("midRstErrLatency", firstErrAt, FL + 3);
        check("midRstErrs", errSeen, 1);
        check("midRstSteps", stepSeen, 0);
        check("midRstErrCount", 32'(errCountO), 1);

        // Random rotation, glitches, illegal jumps, clears and resets.
        pos = 2;
        for (int it = 0; it < 300; it++) begin
            r = $urandom_range(0, 9);
            c = codes[pos];
            if (r <= 5) begin
                pos = ($urandom_range(0, 1) != 0) ? (pos + 1) % 4 : (pos + 3) % 4;
                c = codes[pos];
                applyStimulus(c[1], c[0], 0, 1, $urandom_range(1, 12));
            end else if (r == 6) begin
                ch = $urandom_range(0, 1);
                g = c ^ ((ch != 0) ? 2'b10 : 2'b01);
                applyStimulus(g[1], g[0], 0, 1, $urandom_range(1, FL - 1));
                applyStimulus(c[1], c[0], 0, 1, 6);
            end else if (r == 7) begin
                pos = (pos + 2) % 4;
                c = codes[pos];
                applyStimulus(c[1], c[0], 0, 1, 8);
            end else if (r == 8) begin
                applyStimulus(c[1], c[0], 1, 1, 1);
            end else begin
                applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, 0,
                              $urandom_range(1, 2));
                applyStimulus(c[1], c[0], 0, 1, 8);
            end
        end
        applyStimulus(codes[pos][1], codes[pos][0], 0, 1, 10);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
